// File: rtl/tug_of_war_core_pkg.sv
// Shared types for the tug-of-war game core.
//   winner_t   : 2-bit round/match winner code (NONE, LEFT, RIGHT)
//   state_t    : game FSM state, also exported on the debug state output
//   center_idx : index of the centre light of an n-light (odd n) strip
package tug_pkg;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'd0,
    WIN_LEFT  = 2'd1,
    WIN_RIGHT = 2'd2
  } winner_t;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    ROUND_WON  = 2'd1,
    MATCH_OVER = 2'd2
  } state_t;

  function automatic int center_idx(input int n);
    return (n - 1) / 2;
  endfunction

endpackage

// File: rtl/tug_of_war_core_if.sv
// Bundle between the game core and the board top level.
//   master : drives press_l / press_r / new_match pulses, observes the outputs
//   slave  : the game core
// Handshake: press_l, press_r and new_match are single-cycle pulses with no
// back-pressure; every high cycle is one event, sampled on the rising clk edge.
// state is a debug view of the game FSM.
interface tug_of_war_core_if #(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W    = 3
);
  import tug_pkg::*;

  logic                  press_l;
  logic                  press_r;
  logic                  new_match;
  logic [NUM_LIGHTS-1:0] leds;
  logic [SCORE_W-1:0]    score_l;
  logic [SCORE_W-1:0]    score_r;
  winner_t               round_winner;
  winner_t               match_winner;
  logic                  playing;
  state_t                state;

  modport master (
    output press_l, press_r, new_match,
    input  leds, score_l, score_r, round_winner, match_winner, playing, state
  );

  modport slave (
    input  press_l, press_r, new_match,
    output leds, score_l, score_r, round_winner, match_winner, playing, state
  );

endinterface

// File: rtl/tug_of_war_core_score_counter.sv
// Round-win counter for one player.
//   clk, reset (async, active low), clear (sync zero), inc (count one win)
//   count  : registered number of round wins, saturating at all-ones
//   at_win : high when this cycle's increment lands exactly on WIN_SCORE
module score_counter #(
  parameter int SCORE_W   = 3,
  parameter int WIN_SCORE = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               inc,
  output logic [SCORE_W-1:0] count,
  output logic               at_win
);

  localparam logic [SCORE_W-1:0] MAX_COUNT = '1;
  localparam logic [SCORE_W:0]   WIN_EXT   = (SCORE_W+1)'(WIN_SCORE);

  logic [SCORE_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != MAX_COUNT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
  // One extra bit so the sum cannot wrap onto WIN_SCORE.
  assign at_win = (({1'b0, count_q} + {{SCORE_W{1'b0}}, inc}) == WIN_EXT);

endmodule

// File: rtl/tug_of_war_core.sv
// Tug-of-war game core: light position, per-player round scores, match FSM.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : slave side of tug_of_war_core_if (press pulses in; leds, scores,
//           winner codes, playing and debug state out, all registered)
module tug_of_war_core
  import tug_pkg::*;
#(
  parameter int NUM_LIGHTS  = 9,
  parameter int SCORE_W     = 3,
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input logic               clk,
  input logic               reset,
  tug_of_war_core_if.slave  bus
);

  localparam int POS_W  = $clog2(NUM_LIGHTS);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [POS_W-1:0]      POS_CENTER = POS_W'(center_idx(NUM_LIGHTS));
  localparam logic [POS_W-1:0]      POS_LAST   = POS_W'(NUM_LIGHTS - 1);
  localparam logic [HOLD_W-1:0]     HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [NUM_LIGHTS-1:0] LED_ONE    = {{(NUM_LIGHTS-1){1'b0}}, 1'b1};
  localparam logic [NUM_LIGHTS-1:0] LED_CENTER = LED_ONE << POS_CENTER;

  state_t                state_q, state_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic [NUM_LIGHTS-1:0] leds_q, leds_d;
  winner_t               rw_q, rw_d;
  winner_t               mw_q, mw_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic                  playing_q, playing_d;

  logic win_l, win_r, clear;
  logic at_win_l, at_win_r;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    rw_d    = rw_q;
    mw_d    = mw_q;
    hold_d  = hold_q;
    win_l   = 1'b0;
    win_r   = 1'b0;
    clear   = 1'b0;

    if (bus.new_match) begin
      clear   = 1'b1;
      state_d = PLAY;
      pos_d   = POS_CENTER;
      rw_d    = WIN_NONE;
      mw_d    = WIN_NONE;
      hold_d  = '0;
    end else begin
      case (state_q)
        PLAY: begin
          // A simultaneous pull from both sides cancels out.
          if (bus.press_l && !bus.press_r) begin
            if (pos_q == POS_LAST) win_l = 1'b1;
            else                   pos_d = pos_q + 1'b1;
          end else if (bus.press_r && !bus.press_l) begin
            if (pos_q == '0) win_r = 1'b1;
            else             pos_d = pos_q - 1'b1;
          end
          if (win_l || win_r) begin
            rw_d = win_l ? WIN_LEFT : WIN_RIGHT;
            if ((win_l && at_win_l) || (win_r && at_win_r)) begin
              state_d = MATCH_OVER;
              mw_d    = win_l ? WIN_LEFT : WIN_RIGHT;
            end else begin
              state_d = ROUND_WON;
              hold_d  = HOLD_LOAD;
            end
          end
        end
        ROUND_WON: begin
          // Load value HOLD_CYCLES-1 plus the exit cycle gives HOLD_CYCLES cycles.
          if (hold_q == '0) begin
            state_d = PLAY;
            pos_d   = POS_CENTER;
            rw_d    = WIN_NONE;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
        MATCH_OVER: begin
          state_d = MATCH_OVER;
        end
        default: begin
          state_d = PLAY;
          pos_d   = POS_CENTER;
        end
      endcase
    end

    leds_d    = LED_ONE << pos_d;
    playing_d = (state_d == PLAY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= PLAY;
      pos_q     <= POS_CENTER;
      leds_q    <= LED_CENTER;
      rw_q      <= WIN_NONE;
      mw_q      <= WIN_NONE;
      hold_q    <= '0;
      playing_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      leds_q    <= leds_d;
      rw_q      <= rw_d;
      mw_q      <= mw_d;
      hold_q    <= hold_d;
      playing_q <= playing_d;
    end
  end

  score_counter #(.SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE)) u_score_l (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .inc    (win_l),
    .count  (bus.score_l),
    .at_win (at_win_l)
  );

  score_counter #(.SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE)) u_score_r (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .inc    (win_r),
    .count  (bus.score_r),
    .at_win (at_win_r)
  );

  assign bus.leds         = leds_q;
  assign bus.round_winner = rw_q;
  assign bus.match_winner = mw_q;
  assign bus.playing      = playing_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_tug_of_war_core.sv
// Three game cores (9, 3 and 15 lights) run side by side from one clock and
// reset; only one receives presses at a time, the others see idle cycles.
module tb_tug_of_war_core;
  import tug_pkg::*;

  localparam int WIN = 2;
  localparam int SMAX = 7;

  localparam int M_PLAY = 0;
  localparam int M_HOLD = 1;
  localparam int M_OVER = 2;

  typedef struct {
    int pos;
    int sl;
    int sr;
    int rw;
    int mw;
    int st;
    int hold_left;
  } mdl_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  int   n_of[3]    = '{9, 3, 15};
  int   hold_of[3] = '{3, 1, 1};
  mdl_t mdl[3];

  tug_of_war_core_if #(.NUM_LIGHTS(9),  .SCORE_W(3)) if9 ();
  tug_of_war_core_if #(.NUM_LIGHTS(3),  .SCORE_W(3)) if3 ();
  tug_of_war_core_if #(.NUM_LIGHTS(15), .SCORE_W(3)) if15 ();

  tug_of_war_core #(.NUM_LIGHTS(9), .SCORE_W(3), .WIN_SCORE(WIN), .HOLD_CYCLES(3)) dut9 (
    .clk(clk), .reset(reset), .bus(if9));
  tug_of_war_core #(.NUM_LIGHTS(3), .SCORE_W(3), .WIN_SCORE(WIN), .HOLD_CYCLES(1)) dut3 (
    .clk(clk), .reset(reset), .bus(if3));
  tug_of_war_core #(.NUM_LIGHTS(15), .SCORE_W(3), .WIN_SCORE(WIN), .HOLD_CYCLES(1)) dut15 (
    .clk(clk), .reset(reset), .bus(if15));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic mdl_t model_reset(int n);
    mdl_t m;
    m.pos = (n - 1) / 2;
    m.sl = 0; m.sr = 0; m.rw = 0; m.mw = 0; m.st = M_PLAY; m.hold_left = 0;
    return m;
  endfunction

  function automatic mdl_t model_step(mdl_t m, int n, int hold, bit l, bit r, bit nm);
    mdl_t o;
    int   side;
    o = m;
    side = 0;
    if (nm) return model_reset(n);
    if (m.st == M_PLAY) begin
      if (l && !r) begin
        if (m.pos == n - 1) side = 1; else o.pos = m.pos + 1;
      end else if (r && !l) begin
        if (m.pos == 0) side = 2; else o.pos = m.pos - 1;
      end
      if (side != 0) begin
        int s;
        s = (side == 1) ? m.sl : m.sr;
        if (s < SMAX) s = s + 1;
        if (side == 1) o.sl = s; else o.sr = s;
        o.rw = side;
        if (s == WIN) begin
          o.st = M_OVER;
          o.mw = side;
        end else begin
          o.st = M_HOLD;
          o.hold_left = hold;
        end
      end
    end else if (m.st == M_HOLD) begin
      o.hold_left = m.hold_left - 1;
      if (o.hold_left == 0) begin
        o.st  = M_PLAY;
        o.pos = (n - 1) / 2;
        o.rw  = 0;
      end
    end
    return o;
  endfunction

  // ---------------- checker ----------------
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver / monitor ----------------
  task automatic set_inputs(int k, bit l, bit r, bit nm);
    if9.press_l  = 1'b0; if9.press_r  = 1'b0; if9.new_match  = 1'b0;
    if3.press_l  = 1'b0; if3.press_r  = 1'b0; if3.new_match  = 1'b0;
    if15.press_l = 1'b0; if15.press_r = 1'b0; if15.new_match = 1'b0;
    case (k)
      0: begin if9.press_l  = l; if9.press_r  = r; if9.new_match  = nm; end
      1: begin if3.press_l  = l; if3.press_r  = r; if3.new_match  = nm; end
      2: begin if15.press_l = l; if15.press_r = r; if15.new_match = nm; end
      default: ;
    endcase
  endtask

  task automatic get_out(int k, output logic [31:0] leds, output logic [31:0] sl,
                         output logic [31:0] sr, output logic [31:0] rw,
                         output logic [31:0] mw, output logic [31:0] pl,
                         output logic [31:0] st);
    case (k)
      0: begin
        leds = 32'(if9.leds); sl = 32'(if9.score_l); sr = 32'(if9.score_r);
        rw = 32'(if9.round_winner); mw = 32'(if9.match_winner);
        pl = 32'(if9.playing); st = 32'(if9.state);
      end
      1: begin
        leds = 32'(if3.leds); sl = 32'(if3.score_l); sr = 32'(if3.score_r);
        rw = 32'(if3.round_winner); mw = 32'(if3.match_winner);
        pl = 32'(if3.playing); st = 32'(if3.state);
      end
      default: begin
        leds = 32'(if15.leds); sl = 32'(if15.score_l); sr = 32'(if15.score_r);
        rw = 32'(if15.round_winner); mw = 32'(if15.match_winner);
        pl = 32'(if15.playing); st = 32'(if15.state);
      end
    endcase
  endtask

  task automatic compare_all();
    logic [31:0] leds, sl, sr, rw, mw, pl, st;
    for (int j = 0; j < 3; j++) begin
      get_out(j, leds, sl, sr, rw, mw, pl, st);
      check($sformatf("n%0d_leds", n_of[j]), leds, 32'(1) << mdl[j].pos);
      check($sformatf("n%0d_score_l", n_of[j]), sl, mdl[j].sl);
      check($sformatf("n%0d_score_r", n_of[j]), sr, mdl[j].sr);
      check($sformatf("n%0d_round_winner", n_of[j]), rw, mdl[j].rw);
      check($sformatf("n%0d_match_winner", n_of[j]), mw, mdl[j].mw);
      check($sformatf("n%0d_playing", n_of[j]), pl, (mdl[j].st == M_PLAY) ? 1 : 0);
      check($sformatf("n%0d_state", n_of[j]), st, mdl[j].st);
    end
  endtask

  // One clock: drive DUT k, advance every model, sample 1 time unit after the edge.
  task automatic cycle(int k, bit l, bit r, bit nm);
    set_inputs(k, l, r, nm);
    for (int j = 0; j < 3; j++) begin
      if (j == k) mdl[j] = model_step(mdl[j], n_of[j], hold_of[j], l, r, nm);
      else        mdl[j] = model_step(mdl[j], n_of[j], hold_of[j], 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk);
    #1;
    set_inputs(k, 1'b0, 1'b0, 1'b0);
    compare_all();
  endtask

  task automatic expect_out(int k, string tag, int which, logic [31:0] exp);
    logic [31:0] v[7];
    get_out(k, v[0], v[1], v[2], v[3], v[4], v[5], v[6]);
    check(tag, v[which], exp);
  endtask

  // ---------------- stimulus ----------------
  localparam int O_LEDS = 0, O_SL = 1, O_SR = 2, O_RW = 3, O_MW = 4, O_PL = 5, O_ST = 6;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    set_inputs(0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) mdl[j] = model_reset(n_of[j]);
    #12;
    compare_all();
    expect_out(0, "rst_leds9", O_LEDS, 32'h010);
    expect_out(1, "rst_leds3", O_LEDS, 32'h002);
    expect_out(2, "rst_leds15", O_LEDS, 32'h080);
    @(negedge clk);
    reset = 1'b1;

    // Idle after reset.
    repeat (5) cycle(0, 0, 0, 0);
    expect_out(0, "idle_leds", O_LEDS, 32'h010);
    expect_out(0, "idle_playing", O_PL, 1);

    // Left walks to the end, then wins a round.
    repeat (4) cycle(0, 1, 0, 0);
    expect_out(0, "walk_end_leds", O_LEDS, 32'h100);
    cycle(0, 1, 1, 0);
    expect_out(0, "both_at_end_leds", O_LEDS, 32'h100);
    cycle(0, 1, 0, 0);
    expect_out(0, "win_score_l", O_SL, 1);
    expect_out(0, "win_round_winner", O_RW, 1);
    expect_out(0, "hold1_playing", O_PL, 0);
    cycle(0, 1, 0, 0);
    expect_out(0, "hold2_playing", O_PL, 0);
    expect_out(0, "hold2_leds", O_LEDS, 32'h100);
    cycle(0, 0, 1, 0);
    expect_out(0, "hold3_playing", O_PL, 0);
    cycle(0, 0, 0, 0);
    expect_out(0, "after_hold_leds", O_LEDS, 32'h010);
    expect_out(0, "after_hold_rw", O_RW, 0);
    expect_out(0, "after_hold_playing", O_PL, 1);

    // Both at centre: no movement.
    cycle(0, 1, 1, 0);
    expect_out(0, "both_centre_leds", O_LEDS, 32'h010);

    // Right wins two rounds and the match.
    for (int rnd = 0; rnd < 2; rnd++) begin
      repeat (5) cycle(0, 0, 1, 0);
      if (rnd == 0) repeat (3) cycle(0, 0, 0, 0);
    end
    expect_out(0, "match_score_r", O_SR, 2);
    expect_out(0, "match_winner", O_MW, 2);
    expect_out(0, "match_state", O_ST, 2);
    repeat (10) cycle(0, $urandom_range(0, 1), $urandom_range(0, 1), 0);
    expect_out(0, "frozen_leds", O_LEDS, 32'h001);
    expect_out(0, "frozen_score_l", O_SL, 1);
    cycle(0, 0, 0, 1);
    expect_out(0, "restart_score_r", O_SR, 0);
    expect_out(0, "restart_leds", O_LEDS, 32'h010);
    expect_out(0, "restart_playing", O_PL, 1);

    // new_match beats a winning press at the end light.
    repeat (4) cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 1);
    expect_out(0, "nm_prio_score_l", O_SL, 0);
    expect_out(0, "nm_prio_leds", O_LEDS, 32'h010);

    // Reset asserted mid-hold acts without a clock edge.
    repeat (5) cycle(0, 1, 0, 0);
    expect_out(0, "pre_reset_playing", O_PL, 0);
    #2;
    reset = 1'b0;
    #1;
    for (int j = 0; j < 3; j++) mdl[j] = model_reset(n_of[j]);
    expect_out(0, "async_rst_leds", O_LEDS, 32'h010);
    expect_out(0, "async_rst_score_l", O_SL, 0);
    expect_out(0, "async_rst_playing", O_PL, 1);
    expect_out(0, "async_rst_rw", O_RW, 0);
    @(negedge clk);
    reset = 1'b1;

    // Three lights, one-cycle hold.
    cycle(1, 1, 0, 0);
    expect_out(1, "n3_move_leds", O_LEDS, 32'h4);
    cycle(1, 1, 0, 0);
    expect_out(1, "n3_win_score_l", O_SL, 1);
    expect_out(1, "n3_hold_playing", O_PL, 0);
    cycle(1, 0, 0, 0);
    expect_out(1, "n3_back_leds", O_LEDS, 32'h2);
    expect_out(1, "n3_back_playing", O_PL, 1);

    // Fifteen lights, one-cycle hold.
    repeat (7) cycle(2, 0, 1, 0);
    expect_out(2, "n15_end_leds", O_LEDS, 32'h1);
    cycle(2, 0, 1, 0);
    expect_out(2, "n15_win_score_r", O_SR, 1);
    expect_out(2, "n15_hold_playing", O_PL, 0);
    cycle(2, 0, 0, 0);
    expect_out(2, "n15_back_leds", O_LEDS, 32'h80);

    // Random play on every core.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 400; i++) begin
        int  x;
        bit  l, r, nm;
        x  = $urandom_range(0, 9);
        l  = (x <= 3) || (x == 8);
        r  = ((x >= 4) && (x <= 7)) || (x == 8);
        nm = ($urandom_range(0, 49) == 0);
        cycle(k, l, r, nm);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tug_of_war_core.md
Name: tug_of_war_core

Overview:
- Parametrised game core for the tug-of-war board; generalises the fixed 9-light, one-round game.
- Holds light position, per-player round scores and match state.
- Takes already-conditioned single-cycle press pulses from the existing metastability and user-input stages.
- Drives LEDR lights and winner codes; the top level maps the codes to HEX displays.

Parameters:
- NUM_LIGHTS, 9: number of lights; must be odd and >= 3; CENTER = (NUM_LIGHTS-1)/2.
- SCORE_W, 3: width of each score output.
- WIN_SCORE, 7: round wins needed to win the match; must satisfy 1 <= WIN_SCORE <= 2**SCORE_W - 1.
- HOLD_CYCLES, 4: cycles the winning light is frozen after a round win; must be >= 1.

Ports:
- clk  input  1: system clock (CLOCK_50 at the top).
- reset  input  1: asynchronous, active-low reset (0 = in reset).
- press_l  input  1: one-cycle pulse, left player pull (toward index NUM_LIGHTS-1).
- press_r  input  1: one-cycle pulse, right player pull (toward index 0).
- new_match  input  1: one-cycle pulse that restarts the match.
- leds  output  NUM_LIGHTS: one-hot light position.
- score_l  output  SCORE_W: left player round wins.
- score_r  output  SCORE_W: right player round wins.
- round_winner  output  2: winner_t of the last round, valid in ROUND_WON and MATCH_OVER.
- match_winner  output  2: winner_t of the match, valid in MATCH_OVER.
- playing  output  1: high in PLAY.

Behaviour:
- All outputs are registered. Inputs sampled at edge N take effect on the outputs after edge N (1-cycle latency).
- Reset (reset=0, asynchronous) sets:
  - state=PLAY, leds = 1<<CENTER, scores 0, round_winner=match_winner=WIN_NONE, playing=1, hold counter 0.
- Reset release is synchronous to clk in the top level.

State machine (states PLAY, ROUND_WON, MATCH_OVER):
- PLAY:
  - press_l alone: pos+1 if pos<NUM_LIGHTS-1. If pos==NUM_LIGHTS-1, left wins the round.
  - press_r alone: pos-1 if pos>0. If pos==0, right wins the round.
  - Both presses in the same cycle, or neither: no change.
  - Round win: the winner's score increments and round_winner is set.
    - If the new score == WIN_SCORE: go to MATCH_OVER and set match_winner.
    - Otherwise: go to ROUND_WON and load the hold counter with HOLD_CYCLES-1.
  - leds stay on the end light in both cases.
- ROUND_WON:
  - press_l/press_r are ignored; playing=0.
  - The counter decrements each cycle. The state lasts exactly HOLD_CYCLES cycles.
  - On the cycle the counter reaches 0, the next state is PLAY with leds = 1<<CENTER and round_winner = WIN_NONE.
- MATCH_OVER:
  - Presses are ignored; all outputs are frozen.
  - The state is left only by new_match or reset.
- new_match (any state):
  - Has priority over presses in the same cycle.
  - Next cycle: state PLAY, leds centred, scores 0, both winners WIN_NONE, counter 0.
- Scores cannot exceed WIN_SCORE by construction; the increment saturates at 2**SCORE_W-1 as a safety measure.
- leds is never all-zero and never multi-hot.
- Reset mid-hold or mid-match aborts immediately; no partial state survives.

Decomposition:
- Package tug_pkg:
  - winner_t enum, 2 bits: WIN_NONE=0, WIN_LEFT=1, WIN_RIGHT=2.
  - state_t enum: PLAY, ROUND_WON, MATCH_OVER.
  - function center_idx(n) returning (n-1)/2.
- Sub-module score_counter, instantiated twice:
  - Parameters SCORE_W and WIN_SCORE.
  - Inputs clk, reset, clear, inc.
  - Outputs count and at_win, where at_win = (count+inc == WIN_SCORE).
- Position is kept as an index of width $clog2(NUM_LIGHTS) and decoded to one-hot.

Test Plan (NUM_LIGHTS=9, WIN_SCORE=2, HOLD_CYCLES=3 unless stated):
- Reset then idle 5 cycles -> leds=9'b000010000, scores 0, playing=1, both winners 0.
- 4 press_l pulses, then 1 more -> leds=9'b100000000 after the 4th. After the 5th: score_l=1, round_winner=1, playing=0 for exactly 3 cycles, then leds=9'b000010000, round_winner=0.
- press_l and press_r together at centre, and at pos 8 -> no movement, no score change. Presses during the ROUND_WON hold -> ignored, leds unchanged.
- Right wins two rounds (5 press_r each) -> after the 2nd: score_r=2, match_winner=2, MATCH_OVER. 10 further presses -> no output change. new_match -> next cycle scores 0, centred, playing=1.
- Drop reset to 0 mid-hold (between clock edges) -> outputs reach reset values immediately without a clock edge.
- new_match and press_l together at pos 8 -> restart wins, score_l stays 0.
- Repeat the move/win checks with NUM_LIGHTS=3 and NUM_LIGHTS=15, HOLD_CYCLES=1 -> centre index 1 and 7; a one-cycle hold is observed.
